// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one external combinational ALU between two
// requesters. Round-robin arbitration on ties, operands and funct are
// registered toward the ALU, and the ALU result is captured and held on the
// winner's response channel until that requester accepts it.
module alu_share_arbiter #(
    parameter int DATA_W    = 32,
    parameter int FUNCT_W   = 6,
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [DATA_W-1:0]  req0_a,
    input  logic [DATA_W-1:0]  req0_b,
    input  logic [FUNCT_W-1:0] req0_funct,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [DATA_W-1:0]  req1_a,
    input  logic [DATA_W-1:0]  req1_b,
    input  logic [FUNCT_W-1:0] req1_funct,
    output logic               rsp0_valid,
    input  logic               rsp0_ready,
    output logic [DATA_W-1:0]  rsp0_data,
    output logic               rsp0_err,
    output logic               rsp1_valid,
    input  logic               rsp1_ready,
    output logic [DATA_W-1:0]  rsp1_data,
    output logic               rsp1_err,
    output logic [DATA_W-1:0]  alu_dataA,
    output logic [DATA_W-1:0]  alu_dataB,
    output logic [FUNCT_W-1:0] alu_Signal,
    input  logic [DATA_W-1:0]  alu_dataOut
);

    localparam logic [FUNCT_W-1:0] FN_ADD = FUNCT_W'(32);
    localparam logic [FUNCT_W-1:0] FN_SUB = FUNCT_W'(34);
    localparam logic [FUNCT_W-1:0] FN_AND = FUNCT_W'(36);
    localparam logic [FUNCT_W-1:0] FN_OR  = FUNCT_W'(37);
    localparam logic [FUNCT_W-1:0] FN_SLT = FUNCT_W'(42);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t              state_reg;
    logic                prio_reg;    // requester that wins the next tie
    logic                owner_reg;   // requester owning the in-flight op
    logic [DATA_W-1:0]   alu_a_reg;
    logic [DATA_W-1:0]   alu_b_reg;
    logic [FUNCT_W-1:0]  alu_funct_reg;
    logic [1:0]          rsp_valid_reg;
    logic [1:0]          rsp_err_reg;
    logic [DATA_W-1:0]   rsp_data_reg [2];

    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0]          rsp_ready;
    logic [1:0]          grant;
    logic                funct_legal;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;
    logic [FUNCT_W-1:0]  sel_funct;

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            // A requester wins when it is alone, or on a tie when the pointer names it
            assign grant[gi]     = req_valid[gi] & (~req_valid[1-gi] | (prio_reg == 1'(gi)));
            assign req_ready[gi] = (state_reg == IDLE) & grant[gi];
        end
    endgenerate

    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];

    // Operand select follows the grant; only one grant bit can be set
    assign sel_a     = grant[1] ? req1_a     : req0_a;
    assign sel_b     = grant[1] ? req1_b     : req0_b;
    assign sel_funct = grant[1] ? req1_funct : req0_funct;

    assign alu_dataA  = alu_a_reg;
    assign alu_dataB  = alu_b_reg;
    assign alu_Signal = alu_funct_reg;

    assign rsp0_valid = rsp_valid_reg[0];
    assign rsp0_data  = rsp_data_reg[0];
    assign rsp0_err   = rsp_err_reg[0];
    assign rsp1_valid = rsp_valid_reg[1];
    assign rsp1_data  = rsp_data_reg[1];
    assign rsp1_err   = rsp_err_reg[1];

    // Decode whether the registered funct is one the ALU implements
    always_comb begin
        funct_legal = 1'b0;
        case (alu_funct_reg)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_legal = 1'b1;
            default:                               funct_legal = 1'b0;
        endcase
    end

    // Sequencer: accept in IDLE, let the ALU settle in ISSUE, hold result in RESP
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            prio_reg      <= PRIO_INIT;
            owner_reg     <= 1'b0;
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            alu_funct_reg <= '0;
            rsp_valid_reg <= '0;
            rsp_err_reg   <= '0;
            rsp_data_reg  <= '{default: '0};
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant != 2'b00) begin
                        alu_a_reg     <= sel_a;
                        alu_b_reg     <= sel_b;
                        alu_funct_reg <= sel_funct;
                        owner_reg     <= grant[1];
                        // the loser of this grant wins the next tie
                        prio_reg      <= ~grant[1];
                        state_reg     <= ISSUE;
                    end
                end
                ISSUE: begin
                    rsp_valid_reg[owner_reg] <= 1'b1;
                    rsp_data_reg[owner_reg]  <= funct_legal ? alu_dataOut : '0;
                    rsp_err_reg[owner_reg]   <= ~funct_legal;
                    state_reg                <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner_reg]) begin
                        rsp_valid_reg[owner_reg] <= 1'b0;
                        state_reg                <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level reference model.
module tb_alu_share_arbiter;

    localparam int DATA_W    = 32;
    localparam int FUNCT_W   = 6;
    localparam bit PRIO_INIT = 1'b0;

    logic               clk = 1'b0;
    logic               reset;
    logic               req0_valid, req0_ready, req1_valid, req1_ready;
    logic [DATA_W-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic [FUNCT_W-1:0] req0_funct, req1_funct;
    logic               rsp0_valid, rsp0_ready, rsp0_err;
    logic               rsp1_valid, rsp1_ready, rsp1_err;
    logic [DATA_W-1:0]  rsp0_data, rsp1_data;
    logic [DATA_W-1:0]  alu_dataA, alu_dataB, alu_dataOut;
    logic [FUNCT_W-1:0] alu_Signal;

    alu_share_arbiter #(
        .DATA_W(DATA_W), .FUNCT_W(FUNCT_W), .PRIO_INIT(PRIO_INIT)
    ) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_funct(req0_funct),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_funct(req1_funct),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
        .alu_dataA(alu_dataA), .alu_dataB(alu_dataB),
        .alu_Signal(alu_Signal), .alu_dataOut(alu_dataOut)
    );

    always #5 clk = ~clk;

    // External ALU; unknown codes return a nonzero pattern so zero-forcing is visible
    always_comb begin
        alu_dataOut = 32'hDEAD_BEEF;
        case (alu_Signal)
            6'd32: alu_dataOut = alu_dataA + alu_dataB;
            6'd34: alu_dataOut = alu_dataA - alu_dataB;
            6'd36: alu_dataOut = alu_dataA & alu_dataB;
            6'd37: alu_dataOut = alu_dataA | alu_dataB;
            6'd42: alu_dataOut = {31'd0, $signed(alu_dataA) < $signed(alu_dataB)};
            default: alu_dataOut = 32'hDEAD_BEEF;
        endcase
    end

    // Requester side stimulus
    bit                 pv [2];
    logic [DATA_W-1:0]  pa [2];
    logic [DATA_W-1:0]  pb [2];
    logic [FUNCT_W-1:0] pf [2];
    bit                 rr [2];

    // Reference model state (transaction level)
    int                 cyc;
    bit                 busy;
    int                 owner;
    int                 acc_cyc;
    int                 last_win;
    logic [DATA_W-1:0]  ma, mb;
    logic [FUNCT_W-1:0] mf;
    bit                 after_rst;
    int                 n_ops;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit is_legal(input logic [FUNCT_W-1:0] f);
        return (f == 6'd32) || (f == 6'd34) || (f == 6'd36) || (f == 6'd37) || (f == 6'd42);
    endfunction

    function automatic logic [31:0] golden(input logic [FUNCT_W-1:0] f,
                                           input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (f)
            6'd32:   return a + b;
            6'd34:   return a - b;
            6'd36:   return a & b;
            6'd37:   return a | b;
            6'd42:   return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [FUNCT_W-1:0] rand_funct();
        logic [FUNCT_W-1:0] legal [5];
        legal = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
        if ($urandom_range(0, 9) == 0) return FUNCT_W'($urandom_range(0, 63));
        return legal[$urandom_range(0, 4)];
    endfunction

    task automatic new_op(input int i, input logic [FUNCT_W-1:0] f,
                          input logic [31:0] a, input logic [31:0] b);
        pv[i] = 1'b1;
        pf[i] = f;
        pa[i] = a;
        pb[i] = b;
    endtask

    task automatic model_reset();
        busy      = 1'b0;
        owner     = 0;
        last_win  = 1 - int'(PRIO_INIT);
        ma        = '0;
        mb        = '0;
        mf        = '0;
        after_rst = 1'b1;
    endtask

    // One reset cycle; any in-flight op is dropped by both DUT and model
    task automatic reset_cycle();
        reset = 1'b1;
        @(posedge clk);
        model_reset();
        cyc++;
        #1;
        reset = 1'b0;
    endtask

    // One clock cycle: drive, check at negedge, advance the model at posedge
    task automatic run_cycle();
        int win;
        bit exp_v [2];
        bit act_v;
        logic [31:0] act_d;
        bit act_e;
        req0_valid = pv[0]; req0_a = pa[0]; req0_b = pb[0]; req0_funct = pf[0];
        req1_valid = pv[1]; req1_a = pa[1]; req1_b = pb[1]; req1_funct = pf[1];
        rsp0_ready = rr[0]; rsp1_ready = rr[1];
        @(negedge clk);
        win = -1;
        if (!busy) begin
            if (pv[0] && pv[1]) win = 1 - last_win;
            else if (pv[0])     win = 0;
            else if (pv[1])     win = 1;
        end
        chk("req0_ready", {31'd0, req0_ready}, {31'd0, win == 0});
        chk("req1_ready", {31'd0, req1_ready}, {31'd0, win == 1});
        for (int i = 0; i < 2; i++) begin
            exp_v[i] = busy && (owner == i) && (cyc >= acc_cyc + 2);
            act_v = (i == 0) ? rsp0_valid : rsp1_valid;
            act_d = (i == 0) ? rsp0_data  : rsp1_data;
            act_e = (i == 0) ? rsp0_err   : rsp1_err;
            chk($sformatf("rsp%0d_valid", i), {31'd0, act_v}, {31'd0, exp_v[i]});
            if (exp_v[i]) begin
                chk($sformatf("rsp%0d_data", i), act_d, golden(mf, ma, mb));
                chk($sformatf("rsp%0d_err", i), {31'd0, act_e}, {31'd0, !is_legal(mf)});
            end
            if (after_rst) begin
                chk($sformatf("rst_rsp%0d_data", i), act_d, 32'd0);
                chk($sformatf("rst_rsp%0d_err", i), {31'd0, act_e}, 32'd0);
            end
        end
        chk("alu_dataA", alu_dataA, ma);
        chk("alu_dataB", alu_dataB, mb);
        chk("alu_Signal", {26'd0, alu_Signal}, {26'd0, mf});
        @(posedge clk);
        if (win >= 0) begin
            busy     = 1'b1;
            owner    = win;
            acc_cyc  = cyc;
            last_win = win;
            ma = pa[win];
            mb = pb[win];
            mf = pf[win];
            pv[win] = 1'b0;
            n_ops++;
            $display("cycle %0d: accept req%0d funct=%0d a=%h b=%h", cyc, win, mf, ma, mb);
        end else if (busy && (cyc >= acc_cyc + 2) && rr[owner]) begin
            busy = 1'b0;
            $display("cycle %0d: response rsp%0d data=%h err=%0d", cyc, owner,
                     golden(mf, ma, mb), !is_legal(mf));
        end
        after_rst = 1'b0;
        cyc++;
        #1;
    endtask

    initial begin
        cyc   = 0;
        n_ops = 0;
        pv = '{0, 0}; pa = '{0, 0}; pb = '{0, 0}; pf = '{0, 0}; rr = '{1, 1};
        req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0; req0_funct = 0; req1_funct = 0;
        model_reset();
        @(posedge clk); #1;
        reset_cycle();
        reset_cycle();

        // T1: single ADD from requester 0
        new_op(0, 6'd32, 32'd5, 32'd7);
        repeat (4) run_cycle();

        // T2: both requesters continuously valid, ties alternate after a fresh reset
        reset_cycle();
        new_op(0, rand_funct(), $urandom, $urandom);
        new_op(1, rand_funct(), $urandom, $urandom);
        repeat (13) begin
            for (int i = 0; i < 2; i++)
                if (!pv[i]) new_op(i, 6'd32, $urandom, $urandom);
            run_cycle();
        end
        pv = '{0, 0};
        repeat (3) run_cycle();

        // T3: response backpressure on requester 1 while requester 0 waits
        new_op(1, 6'd37, 32'h00F0_0F00, 32'h0000_00FF);
        rr[1] = 1'b0;
        repeat (3) run_cycle();
        new_op(0, 6'd36, 32'hFFFF_0000, 32'h1234_5678);
        repeat (5) run_cycle();
        rr[1] = 1'b1;
        repeat (5) run_cycle();

        // T4: SUB and signed SLT
        new_op(0, 6'd34, 32'd3, 32'd5);
        repeat (4) run_cycle();
        new_op(1, 6'd42, 32'hFFFF_FFFF, 32'd1);
        repeat (4) run_cycle();

        // T5: illegal funct from requester 1
        new_op(1, 6'd0, 32'hAAAA_5555, 32'h1111_2222);
        repeat (4) run_cycle();

        // T6: reset while a response is being held
        new_op(0, 6'd32, 32'h7FFF_FFFF, 32'd1);
        rr[0] = 1'b0;
        repeat (4) run_cycle();
        reset_cycle();
        rr[0] = 1'b1;
        new_op(0, 6'd34, 32'd0, 32'd1);
        repeat (4) run_cycle();

        // Randomized traffic with random response backpressure
        repeat (600) begin
            for (int i = 0; i < 2; i++) begin
                if (!pv[i] && $urandom_range(0, 2) == 0)
                    new_op(i, rand_funct(), $urandom, $urandom);
                rr[i] = ($urandom_range(0, 3) != 0);
            end
            run_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
